in_pcm_mc: RTL and testbench

Multi-channel, pipelined successor to the single-channel input PCM converter. Each accepted sample is a G.711 log-PCM byte with its signal estimate SE and channel number. The block expands the byte to linear (EXPAND) and forms the 16-bit difference signal D (SUBTA), bit-exact with G.726. It sits between the TDM PCM deserialiser and the shared ADPCM encoder core. The law (u/A) is selected per channel, flow control is valid/ready in both directions, and channel order within each frame is checked.

---
 rtl/in_pcm_pkg.sv | 20 ++
 rtl/in_pcm_expand.sv | 37 +++
 rtl/in_pcm_mc.sv | 163 ++++++++++++++++
 tb/tb_in_pcm_mc.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/in_pcm_pkg.sv
// Shared widths, law encodings, expansion constants and order-checker states.
package in_pcm_pkg;

    localparam int unsigned PCM_W = 8;
    localparam int unsigned SE_W  = 15;
    localparam int unsigned SL_W  = 14;
    localparam int unsigned D_W   = 16;

    localparam logic LAW_U = 1'b0;
    localparam logic LAW_A = 1'b1;

    localparam int unsigned      ULAW_BIAS = 33;
    localparam logic [PCM_W-1:0] ALAW_XOR  = 8'h55;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } ord_state_e;

endpackage

// File: rtl/in_pcm_expand.sv
// Combinational G.711 log-PCM to 14-bit linear expansion (G.726 EXPAND).
module in_pcm_expand
    import in_pcm_pkg::*;
(
    input  logic [PCM_W-1:0] s,
    input  logic             law,
    output logic [SL_W-1:0]  sl
);

    logic [PCM_W-1:0] t;
    logic [2:0]       ex;
    logic [3:0]       mant;
    logic [SL_W-1:0]  mag;
    logic             neg;

    // Decode segment/mantissa and apply the per-law magnitude rule and sign.
    always_comb begin
        t    = (law == LAW_A) ? (s ^ ALAW_XOR) : ~s;
        ex   = t[6:4];
        mant = t[3:0];
        if (law == LAW_A) begin
            // A-law: sign bit set means positive; doubled to the 14-bit scale,
            // so segment>0 collapses to (2m+33) << seg.
            neg = ~t[7];
            if (ex == 3'd0) begin
                mag = SL_W'({mant, 1'b1}) << 1;
            end else begin
                mag = (SL_W'({mant, 1'b0}) + SL_W'(ULAW_BIAS)) << ex;
            end
        end else begin
            neg = t[7];
            mag = ((SL_W'({mant, 1'b0}) + SL_W'(ULAW_BIAS)) << ex) - SL_W'(ULAW_BIAS);
        end
        sl = neg ? (-mag) : mag;
    end

endmodule

// File: rtl/in_pcm_mc.sv
// Multi-channel input PCM converter: 3-stage stall pipeline (capture, EXPAND, SUBTA)
// with per-channel law selection and frame channel-order checking.
module in_pcm_mc
    import in_pcm_pkg::*;
#(
    parameter int unsigned NUM_CH = 32,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PCM_W-1:0]  in_s,
    input  logic [SE_W-1:0]   in_se,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_fs,
    input  logic [NUM_CH-1:0] law_cfg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [D_W-1:0]    out_d,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_fs,
    output logic              seq_err,
    output logic [15:0]       err_cnt
);

    // Stage 1: captured sample
    logic             v1_q, v1_d;
    logic [PCM_W-1:0] s1_s_q, s1_s_d;
    logic [SE_W-1:0]  s1_se_q, s1_se_d;
    logic [CH_W-1:0]  s1_ch_q, s1_ch_d;
    logic             s1_fs_q, s1_fs_d;
    logic             s1_law_q, s1_law_d;
    // Stage 2: expanded sample
    logic             v2_q, v2_d;
    logic [SL_W-1:0]  s2_sl_q, s2_sl_d;
    logic [SE_W-1:0]  s2_se_q, s2_se_d;
    logic [CH_W-1:0]  s2_ch_q, s2_ch_d;
    logic             s2_fs_q, s2_fs_d;
    // Stage 3: difference signal
    logic             v3_q, v3_d;
    logic [D_W-1:0]   d3_q, d3_d;
    logic [CH_W-1:0]  ch3_q, ch3_d;
    logic             fs3_q, fs3_d;
    // Order checker
    ord_state_e       state_q, state_d;
    logic [CH_W-1:0]  exp_ch_q, exp_ch_d;
    logic             seq_err_q, seq_err_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic            en1, en2, en3, acc, err;
    logic [SL_W-1:0] sl_c;

    // A stage may load when it is empty or the stage after it is moving.
    assign en3      = !v3_q || out_ready;
    assign en2      = !v2_q || en3;
    assign en1      = !v1_q || en2;
    assign in_ready = en1 && !reset;
    assign acc      = in_valid && in_ready;

    in_pcm_expand u_expand (
        .s   (s1_s_q),
        .law (s1_law_q),
        .sl  (sl_c)
    );

    // Pipeline next-state: hold unless the stage is enabled.
    always_comb begin
        v1_d = v1_q; s1_s_d = s1_s_q; s1_se_d = s1_se_q;
        s1_ch_d = s1_ch_q; s1_fs_d = s1_fs_q; s1_law_d = s1_law_q;
        v2_d = v2_q; s2_sl_d = s2_sl_q; s2_se_d = s2_se_q;
        s2_ch_d = s2_ch_q; s2_fs_d = s2_fs_q;
        v3_d = v3_q; d3_d = d3_q; ch3_d = ch3_q; fs3_d = fs3_q;
        if (en1) begin
            v1_d = acc;
            if (acc) begin
                s1_s_d   = in_s;
                s1_se_d  = in_se;
                s1_ch_d  = in_ch;
                s1_fs_d  = in_fs;
                s1_law_d = law_cfg[in_ch];
            end
        end
        if (en2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_sl_d = sl_c;
                s2_se_d = s1_se_q;
                s2_ch_d = s1_ch_q;
                s2_fs_d = s1_fs_q;
            end
        end
        if (en3) begin
            v3_d = v2_q;
            if (v2_q) begin
                d3_d  = {{(D_W-SL_W){s2_sl_q[SL_W-1]}}, s2_sl_q}
                      - {{(D_W-SE_W){s2_se_q[SE_W-1]}}, s2_se_q};
                ch3_d = s2_ch_q;
                fs3_d = s2_fs_q;
            end
        end
    end

    // Channel-order checker evaluated on each accepted sample.
    always_comb begin
        state_d   = state_q;
        exp_ch_d  = exp_ch_q;
        err_cnt_d = err_cnt_q;
        err       = 1'b0;
        if (acc) begin
            if (state_q == ST_IDLE) begin
                if (in_fs && (in_ch == '0)) begin
                    state_d  = ST_IN_FRAME;
                    exp_ch_d = CH_W'(1);
                end else begin
                    err = 1'b1;
                end
            end else if (in_fs) begin
                err      = (exp_ch_q != '0);
                exp_ch_d = CH_W'(1);
            end else if ((exp_ch_q == '0) || (in_ch != exp_ch_q)) begin
                err      = 1'b1;
                state_d  = ST_IDLE;
                exp_ch_d = '0;
            end else if (exp_ch_q == CH_W'(NUM_CH - 1)) begin
                exp_ch_d = '0;
            end else begin
                exp_ch_d = exp_ch_q + CH_W'(1);
            end
        end
        if (err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        seq_err_d = err;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0; s1_s_q <= '0; s1_se_q <= '0; s1_ch_q <= '0;
            s1_fs_q <= 1'b0; s1_law_q <= LAW_U;
            v2_q <= 1'b0; s2_sl_q <= '0; s2_se_q <= '0; s2_ch_q <= '0; s2_fs_q <= 1'b0;
            v3_q <= 1'b0; d3_q <= '0; ch3_q <= '0; fs3_q <= 1'b0;
            state_q <= ST_IDLE; exp_ch_q <= '0; seq_err_q <= 1'b0; err_cnt_q <= '0;
        end else begin
            v1_q <= v1_d; s1_s_q <= s1_s_d; s1_se_q <= s1_se_d; s1_ch_q <= s1_ch_d;
            s1_fs_q <= s1_fs_d; s1_law_q <= s1_law_d;
            v2_q <= v2_d; s2_sl_q <= s2_sl_d; s2_se_q <= s2_se_d; s2_ch_q <= s2_ch_d;
            s2_fs_q <= s2_fs_d;
            v3_q <= v3_d; d3_q <= d3_d; ch3_q <= ch3_d; fs3_q <= fs3_d;
            state_q <= state_d; exp_ch_q <= exp_ch_d; seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = v3_q;
    assign out_d     = d3_q;
    assign out_ch    = ch3_q;
    assign out_fs    = fs3_q;
    assign seq_err   = seq_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_in_pcm_mc.sv
// Scoreboard bench for in_pcm_mc: reference expansion + order model, stalls, resets.
module tb_in_pcm_mc;

    localparam int NUM_CH = 32;
    localparam int CH_W   = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_s = '0;
    logic [14:0]       in_se = '0;
    logic [CH_W-1:0]   in_ch = '0;
    logic              in_fs = 1'b0;
    logic [NUM_CH-1:0] law_cfg = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_d;
    logic [CH_W-1:0]   out_ch;
    logic              out_fs;
    logic              seq_err;
    logic [15:0]       err_cnt;

    in_pcm_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_se(in_se), .in_ch(in_ch), .in_fs(in_fs), .law_cfg(law_cfg),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_ch(out_ch),
        .out_fs(out_fs), .seq_err(seq_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     d;
        logic [CH_W-1:0] ch;
        logic            fs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rdy_rand = 1'b0;

    // order model state
    bit   m_inframe = 1'b0;
    int   m_exp = 0;
    int   m_cnt = 0;
    bit   err_pend = 1'b0;
    // stall-hold tracking
    bit              hold_v = 1'b0;
    logic [15:0]     hold_d;
    logic [CH_W-1:0] hold_ch;
    logic            hold_fs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // G.711 decode at 16-bit scale, reduced to the 14-bit scale.
    function automatic logic [13:0] ref_expand(input logic [7:0] s, input bit law);
        logic [7:0] t;
        int seg, m, mag;
        bit neg;
        if (!law) begin
            t   = ~s;
            neg = t[7];
            seg = int'(t[6:4]);
            m   = int'(t[3:0]);
            mag = ((((m << 3) + 132) << seg) - 132) / 4;
        end else begin
            t   = s ^ 8'h55;
            neg = !t[7];
            seg = int'(t[6:4]);
            m   = int'(t[3:0]);
            mag = (seg == 0) ? ((m << 4) + 8) : (((m << 4) + 264) << (seg - 1));
            mag = mag / 4;
        end
        return 14'(neg ? -mag : mag);
    endfunction

    function automatic logic [15:0] ref_d(input logic [7:0] s, input logic [14:0] se, input bit law);
        int sl_i, se_i;
        sl_i = int'($signed(ref_expand(s, law)));
        se_i = int'($signed(se));
        return 16'(sl_i - se_i);
    endfunction

    task automatic model_order(input bit fs, input int ch, output bit err);
        err = 1'b0;
        if (!m_inframe) begin
            if (fs && ch == 0) begin m_inframe = 1'b1; m_exp = 1; end
            else err = 1'b1;
        end else if (fs) begin
            err   = (m_exp != 0);
            m_exp = 1;
        end else if (m_exp == 0 || ch != m_exp) begin
            err = 1'b1; m_inframe = 1'b0; m_exp = 0;
        end else begin
            m_exp = (m_exp + 1) % NUM_CH;
        end
    endtask

    // Monitor: values at the negedge are what the next posedge samples.
    always @(negedge clk) begin
        bit   e;
        exp_t x;
        if (reset) begin
            sb.delete();
            m_inframe = 1'b0; m_exp = 0; m_cnt = 0; err_pend = 1'b0; hold_v = 1'b0;
            check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        end else begin
            check_eq("seq_err", 32'(seq_err), 32'(err_pend));
            check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
            err_pend = 1'b0;
            if (hold_v) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_d", 32'(out_d), 32'(hold_d));
                check_eq("stall_ch", 32'(out_ch), 32'(hold_ch));
                check_eq("stall_fs", 32'(out_fs), 32'(hold_fs));
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_d; hold_ch = out_ch; hold_fs = out_fs;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_out", 32'(out_d), 32'hDEAD_BEEF);
                end else begin
                    x = sb.pop_front();
                    check_eq("sb_d", 32'(out_d), 32'(x.d));
                    check_eq("sb_ch", 32'(out_ch), 32'(x.ch));
                    check_eq("sb_fs", 32'(out_fs), 32'(x.fs));
                end
            end
            if (in_valid && in_ready) begin
                x.d  = ref_d(in_s, in_se, law_cfg[in_ch]);
                x.ch = in_ch;
                x.fs = in_fs;
                sb.push_back(x);
                model_order(in_fs, int'(in_ch), e);
                err_pend = e;
                if (e && m_cnt != 16'hFFFF) m_cnt++;
            end
        end
    end

    // Random backpressure when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Drive one sample from posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [7:0] s, input logic [14:0] se, input int ch, input bit fs,
                        output int waits);
        in_valid = 1'b1; in_s = s; in_se = se; in_ch = CH_W'(ch); in_fs = fs;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 1000) begin
                check_eq("send_timeout", 32'(waits), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Single sample into an empty pipe: checks latency and value.
    task automatic one_shot(input logic [7:0] s, input logic [14:0] se, input int ch, input bit fs,
                            input logic [15:0] exp_d);
        in_valid = 1'b1; in_s = s; in_se = se; in_ch = CH_W'(ch); in_fs = fs;
        @(negedge clk);
        check_eq("lat_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); check_eq("lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk); check_eq("lat_c2", 32'(out_valid), 32'd0);
        @(negedge clk); check_eq("lat_c3", 32'(out_valid), 32'd1);
        check_eq("const_d", 32'(out_d), 32'(exp_d));
        check_eq("const_ch", 32'(out_ch), 32'(ch));
        check_eq("const_fs", 32'(out_fs), 32'(fs));
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check_eq("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int w, tot;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_d", 32'(out_d), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // known conversions, in channel order
        law_cfg = 32'h0000_0018;
        one_shot(8'h80, 15'h0000, 0, 1'b1, 16'h1F5F);
        one_shot(8'h00, 15'h0000, 1, 1'b0, 16'hE0A1);
        one_shot(8'hFF, 15'h0010, 2, 1'b0, 16'hFFF0);
        one_shot(8'hD5, 15'h0000, 3, 1'b0, 16'h0002);
        one_shot(8'h2A, 15'h0000, 4, 1'b0, 16'hE080);
        one_shot(8'h80, 15'h7FFF, 5, 1'b0, 16'h1F60);
        check_eq("const_err_cnt", 32'(err_cnt), 32'd0);

        // order errors
        pulse_reset();
        send(8'h11, 15'h0100, 0, 1'b1, w);
        send(8'h22, 15'h0200, 1, 1'b0, w);
        send(8'h33, 15'h0300, 3, 1'b0, w);
        @(negedge clk);
        check_eq("ord_skip_cnt", 32'(err_cnt), 32'd1);
        @(posedge clk); #1;
        send(8'h44, 15'h0400, 5, 1'b0, w);
        @(negedge clk);
        check_eq("ord_nofs_cnt", 32'(err_cnt), 32'd2);
        @(posedge clk); #1;
        send(8'h55, 15'h0500, 0, 1'b1, w);
        send(8'h66, 15'h0600, 1, 1'b0, w);
        @(negedge clk);
        check_eq("ord_resync_cnt", 32'(err_cnt), 32'd2);
        @(posedge clk); #1;
        drain();

        // interleaved frames with alternating law per channel
        pulse_reset();
        for (int f = 0; f < 8; f++) begin
            law_cfg = f[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            for (int c = 0; c < NUM_CH; c++)
                send(8'($urandom), 15'($urandom), c, c == 0, w);
        end
        drain();
        check_eq("reg_err_cnt", 32'(err_cnt), 32'd0);

        // random backpressure, law_cfg changing under samples in flight
        rdy_rand = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'($urandom), 15'($urandom), i % NUM_CH, (i % NUM_CH) == 0, w);
            law_cfg = $urandom;
        end
        @(posedge clk); #1;
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drain();

        // sustained throughput without stalls
        tot = 0;
        for (int i = 0; i < 64; i++) begin
            send(8'($urandom), 15'($urandom), i % NUM_CH, (i % NUM_CH) == 0, w);
            tot += w;
        end
        check_eq("throughput_waits", 32'(tot), 32'd0);
        drain();

        // reset with three samples in flight during a stall
        out_ready = 1'b0;
        send(8'h01, 15'h0001, 0, 1'b1, w);
        send(8'h02, 15'h0002, 1, 1'b0, w);
        send(8'h03, 15'h0003, 2, 1'b0, w);
        @(negedge clk);
        check_eq("full_stall_ready", 32'(in_ready), 32'd0);
        check_eq("full_stall_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_d", 32'(out_d), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(8'h04, 15'h0004, 1, 1'b0, w);
        @(negedge clk);
        check_eq("midrst_idle_err", 32'(err_cnt), 32'd1);
        @(posedge clk); #1;
        drain();

        // saturate the error counter
        pulse_reset();
        for (int i = 0; i < 65538; i++)
            send(8'(i), 15'(i), 1, 1'b0, w);
        @(negedge clk);
        check_eq("sat_err_cnt", 32'(err_cnt), 32'h0000_FFFF);
        @(posedge clk); #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
